// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR width, taps, checker state encoding and step function
package lfsr_pkg;
   localparam int WIDTH = 3;
   localparam logic [WIDTH-1:0] TAPS = 3'b110;
   typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;
   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational LFSR advance, shift left with tap parity in the lsb
module lfsr_step #(
   parameter int W = lfsr_pkg::WIDTH,
   parameter logic [W-1:0] T = lfsr_pkg::TAPS
) (
   input  logic [W-1:0] s,
   output logic [W-1:0] ns
);
   assign ns = {s[W-2:0], ^(s & T)};
endmodule

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: locks onto an upstream LFSR stream and counts mismatches once locked
module lfsr_seq_checker #(
   parameter int WIDTH = lfsr_pkg::WIDTH,
   parameter logic [WIDTH-1:0] TAPS = lfsr_pkg::TAPS,
   parameter int LOCK_N = 4,
   parameter int UNLOCK_N = 3
) (
   input  logic             clk,
   input  logic             rst_syn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [7:0]       err_cnt,
   output logic [1:0]       state
);
   import lfsr_pkg::*;
   localparam int CW = $clog2((LOCK_N > UNLOCK_N ? LOCK_N : UNLOCK_N) + 1);
   localparam logic [CW-1:0] LOCK_C = CW'(LOCK_N);
   localparam logic [CW-1:0] UNLOCK_C = CW'(UNLOCK_N);
   state_t st;
   logic [WIDTH-1:0] pred, step_in, pn;
   logic [CW-1:0] match_cnt, miss_cnt;
   logic hit, nz;
   assign hit = in_data == pred;
   assign nz = |in_data;
   // once locked the prediction free-runs from pred; otherwise it reseeds from the word (equal to pred on a SYNC match)
   assign step_in = st == LOCKED ? pred : in_data;
   assign state = st;
   lfsr_step #(.W(WIDTH), .T(TAPS)) u_step (.s(step_in), .ns(pn));
   // hunt/sync/locked tracking, error strobe and saturating error count
   always_ff @(posedge clk) begin
      if (rst_syn) begin
         st <= HUNT;
         locked <= 1'b0;
         err_pulse <= 1'b0;
         err_cnt <= '0;
         pred <= '0;
         match_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (clr_cnt) err_cnt <= '0;
         if (in_valid) begin
            unique case (st)
               HUNT: if (nz) begin
                  pred <= pn;
                  match_cnt <= '0;
                  st <= SYNC;
               end
               SYNC: if (hit) begin
                  pred <= pn;
                  match_cnt <= match_cnt + 1'b1;
                  if (match_cnt + 1'b1 == LOCK_C) begin
                     st <= LOCKED;
                     locked <= 1'b1;
                     miss_cnt <= '0;
                  end
               end else if (nz) begin
                  pred <= pn;
                  match_cnt <= '0;
               end else begin
                  st <= HUNT;
               end
               LOCKED: begin
                  pred <= pn;
                  if (hit) miss_cnt <= '0;
                  else begin
                     err_pulse <= 1'b1;
                     if (!clr_cnt && err_cnt != 8'hff) err_cnt <= err_cnt + 1'b1;
                     if (miss_cnt + 1'b1 == UNLOCK_C) begin
                        st <= HUNT;
                        locked <= 1'b0;
                        miss_cnt <= '0;
                        match_cnt <= '0;
                     end else begin
                        miss_cnt <= miss_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  st <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
